data_mem_resp: RTL and testbench



---
 rtl/data_mem_resp_pkg.sv | 24 ++
 rtl/data_mem_resp_if.sv | 25 ++
 rtl/data_mem_resp_mem_array_32b.sv | 31 +++
 rtl/data_mem_resp.sv | 109 ++++++++++
 tb/tb_data_mem_resp.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// State encoding, op codes, counter width and the address legality check.
package data_mem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Misaligned byte address, or any bit set above the word-index field.
  function automatic logic addr_bad(input logic [WORD_W-1:0] adr, input int addr_w);
    return (adr[1:0] != 2'b00) || ((adr >> (addr_w + 2)) != '0);
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Datapath-to-data-memory port: address, store data, strobes, load data and status.
// Strobes are held by the master until the one-cycle ready pulse.
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic [WORD_W-1:0] adr;
  logic [WORD_W-1:0] wr_data;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] rd_data;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output adr, wr_data, mem_read, mem_write,
    input  rd_data, ready, err, busy
  );

  modport slave (
    input  adr, wr_data, mem_read, mem_write,
    output rd_data, ready, err, busy
  );

endinterface

// File: rtl/data_mem_resp_mem_array_32b.sv
// DEPTH x 32 word storage: synchronous write, combinational read, async clear.
// Single shared index for read and write; no backpressure.
module mem_array_32b
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: latches one request, accesses after LATENCY cycles, pulses ready.
// Turnaround LATENCY+1 cycles; requests are only accepted in IDLE (busy high otherwise).
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "data_mem_resp: LATENCY must be in 1..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W != $clog2(DEPTH)) begin : g_bad_depth
    $fatal(1, "data_mem_resp: DEPTH must be a power of two >= 2 and ADDR_W = log2(DEPTH)");
  end

  state_t            state_q;
  op_t               op_q;
  logic [WORD_W-1:0] adr_q;
  logic [WORD_W-1:0] wdat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] rd_data_q;
  logic              ready_q;
  logic              err_q;
  logic              busy_q;

  logic              acc_err_d;
  logic              mem_we_d;
  logic [WORD_W-1:0] mem_rdata;

  assign acc_err_d = addr_bad(adr_q, ADDR_W);
  assign mem_we_d  = (state_q == ST_BUSY) && (cnt_q == '0) && (op_q == OP_WRITE) && !acc_err_d;

  mem_array_32b #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we_d),
    .addr_i  (adr_q[ADDR_W+1:2]),
    .wdata_i (wdat_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_READ;
      adr_q     <= '0;
      wdat_q    <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            err_q   <= acc_err_d;
            // Errors zero the load data; valid writes leave it untouched.
            if (acc_err_d) begin
              rd_data_q <= '0;
            end else if (op_q == OP_READ) begin
              rd_data_q <= mem_rdata;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          // IDLE, and the unreachable 2'b11 encoding, behave identically.
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          if (bus.mem_read || bus.mem_write) begin
            op_q    <= bus.mem_write ? OP_WRITE : OP_READ;
            adr_q   <= bus.adr;
            wdat_q  <= bus.wr_data;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= ST_BUSY;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed cases plus random requests
// scored against a word-array reference model.
module tb_data_mem_resp;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic rst;

  data_mem_resp_if bus();

  data_mem_resp #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request; strobes dropped in the DONE cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    int   n;
    logic exp_err;
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.adr       = a;
    bus.wr_data   = wd;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.ready !== 1'b1 && n < 40);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.adr       = $urandom;
    bus.wr_data   = $urandom;
    exp_err = (a % 4 != 0) || (a >= DEPTH * 4);
    if (exp_err) ref_rd = 32'h0;
    else if (wr) ref_mem[a / 4] = wd;
    else         ref_rd = ref_mem[a / 4];
    chk({tag, "/ready_cycle"}, n, LAT + 1);
    chk({tag, "/err"}, bus.err, exp_err);
    chk({tag, "/rd_data"}, bus.rd_data, ref_rd);
    chk({tag, "/busy_done"}, bus.busy, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, "/ready_clr"}, bus.ready, 1'b0);
    chk({tag, "/busy_clr"}, bus.busy, 1'b0);
  endtask

  initial begin
    int          last;
    int          pulses;
    logic        rd;
    logic        wr;
    logic [31:0] a;

    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.adr       = '0;
    bus.wr_data   = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_rd = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset/rd_data", bus.rd_data, 32'h0);
    chk("reset/ready", bus.ready, 1'b0);
    chk("reset/err", bus.err, 1'b0);
    chk("reset/busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "t1_write");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, "t1_read");
    do_req(1'b1, 1'b0, 32'h12, 32'h0, "t2_misaligned");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, "t2_reread");
    do_req(1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, "t3_oor_write");
    do_req(1'b1, 1'b0, 32'h0, 32'h0, "t3_read0");
    do_req(1'b1, 1'b1, 32'h8, 32'h12345678, "t4_both");
    do_req(1'b1, 1'b0, 32'h8, 32'h0, "t4_read");
    do_req(1'b0, 1'b1, 32'h4, 32'h0BADF00D, "t5_seed");

    // Strobe held across DONE: new request every LAT+2 cycles.
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.adr      = 32'h4;
    last   = 0;
    pulses = 0;
    for (int c = 1; c <= 3 * (LAT + 2); c++) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) begin
        pulses++;
        if (last > 0) chk("t5_gap", c - last, LAT + 2);
        else          chk("t5_first", c, LAT + 1);
        chk("t5_rd_data", bus.rd_data, ref_mem[1]);
        last = c;
      end
    end
    bus.mem_read = 1'b0;
    ref_rd = ref_mem[1];
    chk("t5_pulses", pulses, 3);
    chk("t5_idle_busy", bus.busy, 1'b0);

    // Reset while a write is in flight.
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.adr       = 32'h20;
    bus.wr_data   = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    chk("t6_accepted", bus.busy, 1'b1);
    bus.mem_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_ready", bus.ready, 1'b0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_rd = 32'h0;
    pulses = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) pulses++;
    end
    chk("t6_no_ready", pulses, 0);
    chk("t6_rd_data", bus.rd_data, 32'h0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, "t6_read");

    // Random traffic: mostly a small valid window so reads hit earlier writes.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = $urandom_range(0, 15) * 4;
        2:       a = $urandom_range(0, DEPTH * 4 - 1);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      do_req(rd, wr, a, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
